// File: rtl/adsr_env_if.sv
// Register-slot bus between a host and the ADSR envelope generator.
// The master drives the strobes, address and write data; the slave returns read data.
interface adsr_env_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output cs, read, write, addr, write_data,
    input  read_data
  );

  modport slave (
    input  cs, read, write, addr, write_data,
    output read_data
  );
endinterface

// File: rtl/adsr_env_io.sv
// ADSR envelope generator with a register slot.
// A 32-bit amplitude accumulator drives a Q2.14 envelope output.
module adsr_env_io (
  input  logic        clk,
  input  logic        rst,
  adsr_env_if.slave   bus,
  output logic [15:0] env_out,
  output logic        idle
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_ATTACK  = 3'd2,
    S_DECAY   = 3'd3,
    S_SUSTAIN = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [31:0] AMP_MAX = 32'h8000_0000;

  logic [31:0] atk_step, dcy_step, sus_level, rel_step, sus_time;
  logic        bypass;
  state_t      state, state_nxt;
  logic [31:0] amp, amp_nxt;
  logic [31:0] sus_cnt, sus_cnt_nxt;
  logic [32:0] step_res;
  logic        wr_en, ctrl_wr, start, stop;
  logic        read_unused;

  // Each step function returns {phase_done, new_amp}.
  function automatic logic [32:0] atk_next(input logic [31:0] a, input logic [31:0] s);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, s};
    if (s == 32'd0 || sum >= {1'b0, AMP_MAX}) return {1'b1, AMP_MAX};
    return {1'b0, sum[31:0]};
  endfunction

  function automatic logic [31:0] sus_clamp(input logic [31:0] lvl);
    return (lvl > AMP_MAX) ? AMP_MAX : lvl;
  endfunction

  // A borrow out of the subtraction counts as falling below the sustain level.
  function automatic logic [32:0] dcy_next(input logic [31:0] a, input logic [31:0] s,
                                           input logic [31:0] lvl);
    logic [32:0] diff;
    logic [31:0] sus;
    sus  = sus_clamp(lvl);
    diff = {1'b0, a} - {1'b0, s};
    if (s == 32'd0 || diff[32] || diff[31:0] <= sus) return {1'b1, sus};
    return {1'b0, diff[31:0]};
  endfunction

  function automatic logic [32:0] rel_next(input logic [31:0] a, input logic [31:0] s);
    if (s == 32'd0 || a <= s) return {1'b1, 32'd0};
    return {1'b0, a - s};
  endfunction

  assign read_unused = bus.read;
  assign wr_en   = bus.cs & bus.write;
  assign ctrl_wr = wr_en && (bus.addr == 5'd5);
  assign start   = ctrl_wr & bus.write_data[0];
  assign stop    = ctrl_wr & bus.write_data[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      atk_step  <= '0;
      dcy_step  <= '0;
      sus_level <= '0;
      rel_step  <= '0;
      sus_time  <= '0;
      bypass    <= 1'b1;
    end else if (wr_en) begin
      case (bus.addr)
        5'd0: atk_step  <= bus.write_data;
        5'd1: dcy_step  <= bus.write_data;
        5'd2: sus_level <= bus.write_data;
        5'd3: rel_step  <= bus.write_data;
        5'd4: sus_time  <= bus.write_data;
        5'd5: bypass    <= bus.write_data[2];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      amp     <= '0;
      sus_cnt <= '0;
    end else begin
      state   <= state_nxt;
      amp     <= amp_nxt;
      sus_cnt <= sus_cnt_nxt;
    end
  end

  // Start has priority over everything, including a simultaneous stop.
  always_comb begin
    state_nxt   = state;
    amp_nxt     = amp;
    sus_cnt_nxt = sus_cnt;
    step_res    = '0;
    if (start) begin
      state_nxt = S_LAUNCH;
      amp_nxt   = '0;
    end else begin
      case (state)
        S_IDLE:   amp_nxt = '0;
        S_LAUNCH: state_nxt = S_ATTACK;
        S_ATTACK: begin
          if (stop) begin
            state_nxt = S_RELEASE;
          end else begin
            step_res = atk_next(amp, atk_step);
            amp_nxt  = step_res[31:0];
            if (step_res[32]) state_nxt = S_DECAY;
          end
        end
        S_DECAY: begin
          if (stop) begin
            state_nxt = S_RELEASE;
          end else begin
            step_res = dcy_next(amp, dcy_step, sus_level);
            amp_nxt  = step_res[31:0];
            if (step_res[32]) begin
              state_nxt   = S_SUSTAIN;
              sus_cnt_nxt = '0;
            end
          end
        end
        S_SUSTAIN: begin
          if (stop) begin
            state_nxt = S_RELEASE;
          end else begin
            sus_cnt_nxt = sus_cnt + 32'd1;
            // Compared at 33 bits so sus_time of 0 or 1 both give a single cycle.
            if ({1'b0, sus_cnt} + 33'd1 >= {1'b0, sus_time}) state_nxt = S_RELEASE;
          end
        end
        S_RELEASE: begin
          step_res = rel_next(amp, rel_step);
          amp_nxt  = step_res[31:0];
          if (step_res[32]) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          amp_nxt   = '0;
        end
      endcase
    end
  end

  assign env_out = bypass ? 16'h4000 : {1'b0, amp[31:17]};
  assign idle    = (state == S_IDLE);

  always_comb begin
    bus.read_data = '0;
    case (bus.addr)
      5'd0: bus.read_data = atk_step;
      5'd1: bus.read_data = dcy_step;
      5'd2: bus.read_data = sus_level;
      5'd3: bus.read_data = rel_step;
      5'd4: bus.read_data = sus_time;
      5'd5: bus.read_data = {28'd0, bypass, state};
      5'd6: bus.read_data = {16'd0, env_out};
      default: bus.read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_adsr_env_io.sv
// Directed bench for adsr_env_io: a vector table for the main envelope and
// hand-written sequences for zero steps, retrigger, bypass and reset abort.
module tb_adsr_env_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] env_out;
  logic        idle;
  int          checks = 0;
  int          failures = 0;

  adsr_env_if bus ();

  adsr_env_io dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .env_out (env_out),
    .idle    (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  st;
    logic [15:0] env;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     input logic [2:0] st, input logic [15:0] env);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.st = st; v.env = env;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, tag, act, exp);
    end
  endtask

  // One cycle: optional write, then check state, envelope, idle and the env readback.
  task automatic step(input logic wr, input logic [4:0] a, input logic [31:0] d,
                      input logic [2:0] est, input logic [15:0] eenv, input int tag);
    bus.cs = wr; bus.write = wr; bus.addr = a; bus.write_data = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = 5'd5;
    #1;
    chk("state", tag, {29'd0, bus.read_data[2:0]}, {29'd0, est});
    chk("env_out", tag, {16'd0, env_out}, {16'd0, eenv});
    chk("idle", tag, {31'd0, idle}, {31'd0, (est == 3'd0)});
    bus.addr = 5'd6;
    #1;
    chk("env_read", tag, bus.read_data, {16'd0, eenv});
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(nm, a, bus.read_data, exp);
  endtask

  task automatic nop(input logic [2:0] est, input logic [15:0] eenv, input int tag);
    step(1'b0, 5'd0, 32'd0, est, eenv, tag);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [2:0] est, input logic [15:0] eenv, input int tag);
    step(1'b1, a, d, est, eenv, tag);
  endtask

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = 5'd0; bus.write_data = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_env", 0, {16'd0, env_out}, 32'h0000_4000);
    chk("rst_idle", 0, {31'd0, idle}, 32'd1);
    rd("rst_ctrl", 5'd5, 32'h0000_0008);
    rd("rst_atk", 5'd0, 32'd0);

    // Full envelope
    add(1, 0, 32'h2000_0000, 0, 16'h4000);
    add(1, 1, 32'h1000_0000, 0, 16'h4000);
    add(1, 2, 32'h6000_0000, 0, 16'h4000);
    add(1, 3, 32'h2000_0000, 0, 16'h4000);
    add(1, 4, 32'd3,         0, 16'h4000);
    add(1, 5, 32'd0,         0, 16'h0000);
    add(1, 5, 32'd1,         1, 16'h0000);
    add(0, 0, 0, 2, 16'h0000);
    add(0, 0, 0, 2, 16'h1000);
    add(0, 0, 0, 2, 16'h2000);
    add(0, 0, 0, 2, 16'h3000);
    add(0, 0, 0, 3, 16'h4000);
    add(0, 0, 0, 3, 16'h3800);
    add(0, 0, 0, 4, 16'h3000);
    add(0, 0, 0, 4, 16'h3000);
    add(0, 0, 0, 4, 16'h3000);
    add(0, 0, 0, 5, 16'h3000);
    add(0, 0, 0, 5, 16'h2000);
    add(0, 0, 0, 5, 16'h1000);
    add(0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000);
    // Stop during attack at 0x2000
    add(1, 5, 32'd1, 1, 16'h0000);
    add(0, 0, 0, 2, 16'h0000);
    add(0, 0, 0, 2, 16'h1000);
    add(0, 0, 0, 2, 16'h2000);
    add(1, 5, 32'd2, 5, 16'h2000);
    add(0, 0, 0, 5, 16'h1000);
    add(0, 0, 0, 0, 16'h0000);
    // Stop in IDLE is ignored; bypass forces unity
    add(1, 5, 32'd2, 0, 16'h0000);
    add(1, 5, 32'd4, 0, 16'h4000);

    foreach (tbl[i]) step(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].st, tbl[i].env, i);

    rd("rb_atk", 5'd0, 32'h2000_0000);
    rd("rb_dcy", 5'd1, 32'h1000_0000);
    rd("rb_sus", 5'd2, 32'h6000_0000);
    rd("rb_rel", 5'd3, 32'h2000_0000);
    rd("rb_time", 5'd4, 32'd3);
    rd("rb_ctrl", 5'd5, 32'h0000_0008);
    rd("rb_unmapped7", 5'd7, 32'd0);
    rd("rb_unmapped31", 5'd31, 32'd0);

    // Zero steps with an over-range sustain level
    wr(5, 32'd0, 0, 16'h0000, 100);
    wr(0, 32'd0, 0, 16'h0000, 101);
    wr(1, 32'd0, 0, 16'h0000, 102);
    wr(3, 32'd0, 0, 16'h0000, 103);
    wr(4, 32'd0, 0, 16'h0000, 104);
    wr(2, 32'h9000_0000, 0, 16'h0000, 105);
    rd("rb_sus_raw", 5'd2, 32'h9000_0000);
    wr(5, 32'd1, 1, 16'h0000, 106);
    nop(2, 16'h0000, 107);
    nop(3, 16'h4000, 108);
    nop(4, 16'h4000, 109);
    nop(5, 16'h4000, 110);
    nop(0, 16'h0000, 111);

    // Retrigger from SUSTAIN, bypass toggled mid-sustain, start+stop together
    wr(0, 32'h2000_0000, 0, 16'h0000, 200);
    wr(1, 32'h1000_0000, 0, 16'h0000, 201);
    wr(2, 32'h6000_0000, 0, 16'h0000, 202);
    wr(3, 32'h2000_0000, 0, 16'h0000, 203);
    wr(4, 32'd5,         0, 16'h0000, 204);
    wr(5, 32'd1, 1, 16'h0000, 205);
    nop(2, 16'h0000, 206);
    nop(2, 16'h1000, 207);
    nop(2, 16'h2000, 208);
    nop(2, 16'h3000, 209);
    nop(3, 16'h4000, 210);
    nop(3, 16'h3800, 211);
    nop(4, 16'h3000, 212);
    wr(5, 32'd4, 4, 16'h4000, 213);
    wr(5, 32'd0, 4, 16'h3000, 214);
    wr(5, 32'd1, 1, 16'h0000, 215);
    nop(2, 16'h0000, 216);
    nop(2, 16'h1000, 217);
    wr(5, 32'd3, 1, 16'h0000, 218);
    nop(2, 16'h0000, 219);
    nop(2, 16'h1000, 220);
    nop(2, 16'h2000, 221);
    nop(2, 16'h3000, 222);
    nop(3, 16'h4000, 223);
    nop(3, 16'h3800, 224);

    // Asynchronous reset in DECAY, away from the clock edge
    rst = 1'b1;
    #1;
    chk("abort_env", 300, {16'd0, env_out}, 32'h0000_4000);
    chk("abort_idle", 300, {31'd0, idle}, 32'd1);
    rd("abort_ctrl", 5'd5, 32'h0000_0008);
    rd("abort_atk", 5'd0, 32'd0);
    rd("abort_dcy", 5'd1, 32'd0);
    rd("abort_sus", 5'd2, 32'd0);
    rd("abort_rel", 5'd3, 32'd0);
    rd("abort_time", 5'd4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nop(0, 16'h4000, 301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adsr_env_io.md
ADSR_ENV_IO -- requirements
Module: adsr_env_io

Interface
REQ-001 Parameter: none; amplitude accumulator fixed at 32 bits, full scale MAX = 0x8000_0000 (1.0).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cs  input  1  slot select.
REQ-005 read  input  1  slot read strobe; no side effects.
REQ-006 write  input  1  slot write strobe; effective only when cs=1.
REQ-007 addr  input  5  register index.
REQ-008 write_data  input  32  slot write data.
REQ-009 read_data  output  32  slot read data; combinational from addr, independent of cs and read.
REQ-010 env_out  output  16  Q2.14 envelope to the DDFS env input; 0x4000 = 1.0.
REQ-011 idle  output  1  high when the FSM is in IDLE.

Function
REQ-012 Write map (cs&write): addr0 atk_step, addr1 dcy_step, addr2 sus_level, addr3 rel_step, addr4 sus_time, all 32 bits; addr5 control: bit0 start, bit1 stop (one-cycle pulses), bit2 bypass (stored).
REQ-013 Read map: addr0-4 stored registers; addr5 {28'b0, bypass, state[2:0]}; addr6 {16'b0, env_out}; all other addresses 0.
REQ-014 State encoding: IDLE=0, LAUNCH=1, ATTACK=2, DECAY=3, SUSTAIN=4, RELEASE=5.
REQ-015 env_out = 0x4000 when bypass=1; otherwise {1'b0, amp[31:17]}.
REQ-016 start (any state, including active envelope): next state LAUNCH, amp <= 0.
REQ-017 LAUNCH: one cycle, then ATTACK.
REQ-018 ATTACK: if atk_step=0 or amp+atk_step >= MAX (33-bit sum): amp <= MAX, go DECAY; else amp += atk_step.
REQ-019 DECAY: effective sustain S = min(sus_level, MAX); if dcy_step=0 or amp-dcy_step <= S (borrow counts as below): amp <= S, go SUSTAIN, clear sustain counter; else amp -= dcy_step.
REQ-020 SUSTAIN: amp held; counter increments each cycle; after sus_time cycles in SUSTAIN go RELEASE; sus_time=0 leaves after exactly one SUSTAIN cycle.
REQ-021 RELEASE: if rel_step=0 or amp <= rel_step: amp <= 0, go IDLE; else amp -= rel_step.
REQ-022 IDLE: amp = 0; remains until start.
REQ-023 stop in ATTACK, DECAY or SUSTAIN: next state RELEASE, amp unchanged that cycle; ignored in IDLE, LAUNCH, RELEASE.
REQ-024 start and stop in the same write: start wins.
REQ-025 Register writes to step/level/time take effect on the next cycle, including mid-envelope; no restart implied.
REQ-026 bypass affects env_out only; FSM and amp continue running.

Reset
REQ-027 On rst: state IDLE, amp 0, sustain counter 0, all step/level/time registers 0, bypass=1.
REQ-028 Reset outputs: env_out=0x4000, idle=1, read_data per map with these values.
REQ-029 rst asserted mid-envelope aborts immediately to reset values; no release phase.

Verification
REQ-030 Reset: rst pulse -> env_out=0x4000, idle=1, addr5 reads 0x0000_0008.
REQ-031 Full envelope, bypass=0, atk 0x2000_0000, dcy 0x1000_0000, sus_level 0x6000_0000, sus_time 3, rel 0x2000_0000, start -> LAUNCH 1 cycle, env_out 0x1000,0x2000,0x3000,0x4000, then 0x3800,0x3000, held 0x3000 for 3 SUSTAIN cycles, then 0x2000,0x1000,0x0000, idle=1.
REQ-032 Zero steps: atk=dcy=rel=0, sus_time 0, sus_level 0x9000_0000 -> env 0x4000 (clamped), one SUSTAIN cycle, 0x0000 next, IDLE.
REQ-033 stop during ATTACK at env 0x2000 -> next cycle RELEASE with env 0x2000, then ramps down per rel_step to 0.
REQ-034 Retrigger: start during SUSTAIN -> LAUNCH, env_out 0x0000, new attack ramp; start+stop same write -> LAUNCH.
REQ-035 rst asserted during DECAY -> immediately IDLE, env_out 0x4000, all registers 0.
